// File: rtl/divider.sv
// ============================================================================
// Module   : divider
// Brief    : Sequential 8-bit unsigned restoring divider, one step per clock.
//            Optional macro DIVIDER_DIV0_EN adds a div0 flag and a 1-cycle
//            divide-by-zero short-cut.
// Revision : 1.0
// ============================================================================
`default_nettype none

module divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       st,
  input  logic [7:0] Qbus_in,
  input  logic [7:0] Mbus_in,
  output logic [7:0] Abus_out,
  output logic [7:0] Qbus_out,
  output logic       ready
`ifdef DIVIDER_DIV0_EN
  ,
  output logic       div0
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
`ifdef DIVIDER_DIV0_EN
  localparam logic [1:0] S_ZERO = 2'd2;
`endif

  logic [1:0] state;
  logic [1:0] state_next;
  // Committed remainder is always below M, so the 9th bit of A is always zero
  // and only the shifted/trial values need the extra bit.
  logic [7:0] a_reg;
  logic [7:0] q_reg;
  logic [7:0] m_reg;
  logic [2:0] count;
  logic [8:0] a_shift;
  logic [8:0] trial;

  assign a_shift = {a_reg, q_reg[7]};
  assign trial   = a_shift - {1'b0, m_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (st) begin
`ifdef DIVIDER_DIV0_EN
          state_next = (Mbus_in == 8'd0) ? S_ZERO : S_BUSY;
`else
          state_next = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        if (count == 3'd7) begin
          state_next = S_IDLE;
        end
      end
`ifdef DIVIDER_DIV0_EN
      S_ZERO: state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state == S_IDLE);
    Abus_out = a_reg;
    Qbus_out = q_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= 8'd0;
      q_reg <= 8'd0;
      m_reg <= 8'd0;
      count <= 3'd0;
`ifdef DIVIDER_DIV0_EN
      div0  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (st) begin
            a_reg <= 8'd0;
            q_reg <= Qbus_in;
            m_reg <= Mbus_in;
            count <= 3'd0;
`ifdef DIVIDER_DIV0_EN
            if (Mbus_in != 8'd0) begin
              div0 <= 1'b0;
            end
`endif
          end
        end
        S_BUSY: begin
          // Negative trial means the subtraction overshot: keep the shifted value.
          a_reg <= trial[8] ? a_shift[7:0] : trial[7:0];
          q_reg <= {q_reg[6:0], ~trial[8]};
          count <= count + 3'd1;
        end
`ifdef DIVIDER_DIV0_EN
        S_ZERO: begin
          a_reg <= q_reg;
          q_reg <= 8'hFF;
          div0  <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// Directed self-checking bench for divider: arithmetic reference model plus
// hand-computed expectations per vector.
`default_nettype none

module tb_divider;

  logic       clk;
  logic       rst_n;
  logic       st;
  logic [7:0] Qbus_in;
  logic [7:0] Mbus_in;
  logic [7:0] Abus_out;
  logic [7:0] Qbus_out;
  logic       ready;
`ifdef DIVIDER_DIV0_EN
  logic       div0;
`endif

  int checks   = 0;
  int failures = 0;

  logic       exp_valid = 1'b0;
  logic [7:0] exp_q     = 8'd0;
  logic [7:0] exp_a     = 8'd0;
  logic       exp_div0  = 1'b0;

  divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st       (st),
    .Qbus_in  (Qbus_in),
    .Mbus_in  (Mbus_in),
    .Abus_out (Abus_out),
    .Qbus_out (Qbus_out),
`ifdef DIVIDER_DIV0_EN
    .div0     (div0),
`endif
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: {quotient, remainder}; zero divisor yields all-ones and the dividend.
  function automatic logic [15:0] model(input logic [7:0] dd, input logic [7:0] dv);
    if (dv == 8'd0) return {8'hFF, dd};
    return {8'(dd / dv), 8'(dd % dv)};
  endfunction

  function automatic int latency(input logic [7:0] dv);
`ifdef DIVIDER_DIV0_EN
    if (dv == 8'd0) return 1;
`endif
    return 8;
  endfunction

  // Whenever a result is settled, the outputs must match the model every cycle.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("cmp_ready", 32'(ready), 32'd1);
      check("cmp_q", 32'(Qbus_out), 32'(exp_q));
      check("cmp_a", 32'(Abus_out), 32'(exp_a));
`ifdef DIVIDER_DIV0_EN
      check("cmp_div0", 32'(div0), 32'(exp_div0));
`endif
    end
  end

  task automatic do_div(input logic [7:0] dd, input logic [7:0] dv,
                        input logic [7:0] lit_q, input logic [7:0] lit_a,
                        input bit poke);
    logic [15:0] m;
    int lat;
    @(negedge clk);
    Qbus_in = dd;
    Mbus_in = dv;
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    #1;
    st        = 1'b0;
    exp_valid = 1'b0;
    Qbus_in   = 8'($urandom);
    Mbus_in   = 8'($urandom);
    lat       = latency(dv);
    for (int i = 1; i < lat; i++) begin
      check("busy_ready", 32'(ready), 32'd0);
      if (poke && i == 3) st = 1'b1;
      @(posedge clk);
      #1;
      st = 1'b0;
    end
    @(posedge clk);
    #1;
    check("done_ready", 32'(ready), 32'd1);
    check("lit_q", 32'(Qbus_out), 32'(lit_q));
    check("lit_a", 32'(Abus_out), 32'(lit_a));
    m         = model(dd, dv);
    exp_q     = m[15:8];
    exp_a     = m[7:0];
`ifdef DIVIDER_DIV0_EN
    exp_div0  = (dv == 8'd0);
`endif
    exp_valid = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    st      = 1'b0;
    Qbus_in = 8'd0;
    Mbus_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_q", 32'(Qbus_out), 32'd0);
    check("rst_a", 32'(Abus_out), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_valid = 1'b1;

    do_div(8'hDB, 8'h0C, 8'h12, 8'h03, 1'b0);
    do_div(8'hBC, 8'h1C, 8'h06, 8'h14, 1'b0);
    do_div(8'hD7, 8'h13, 8'h0B, 8'h06, 1'b1);
    do_div(8'h05, 8'h09, 8'h00, 8'h05, 1'b0);
    do_div(8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0);
    do_div(8'h37, 8'h00, 8'hFF, 8'h37, 1'b0);
    do_div(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0);

    // Abort a division part-way through with an asynchronous reset.
    @(negedge clk);
    Qbus_in = 8'hDB;
    Mbus_in = 8'h0C;
    st      = 1'b1;
    @(posedge clk);
    #1;
    st        = 1'b0;
    exp_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_q", 32'(Qbus_out), 32'd0);
    check("abort_a", 32'(Abus_out), 32'd0);
`ifdef DIVIDER_DIV0_EN
    check("abort_div0", 32'(div0), 32'd0);
    exp_div0 = 1'b0;
`endif
    @(negedge clk);
    rst_n     = 1'b1;
    exp_q     = 8'd0;
    exp_a     = 8'd0;
    exp_valid = 1'b1;

    do_div(8'hDB, 8'h0C, 8'h12, 8'h03, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
